// File: rtl/saikoro_pkg.sv
// ---------------------------------------------------------------------------
// saikoro_pkg
//   Shared definitions for the saikoro dice chain: roll-controller state
//   encoding, default parameter values (also used by the saikoro bench) and a
//   width helper for the slow-down gap counters.
// ---------------------------------------------------------------------------
package saikoro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_SLOW = 2'd2,
    ST_HOLD = 2'd3
  } roll_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int BASE_GAP_DEF        = 1;
  localparam int SLOW_STEPS_DEF      = 4;

  // The gap doubles after every slow pulse and ends at base_gap<<slow_steps,
  // so this width holds the largest value without wrapping.
  function automatic int gap_width(input int base_gap, input int slow_steps);
    return $clog2(base_gap << slow_steps) + 1;
  endfunction

endpackage

// File: rtl/saikoro_roll_ctrl_if.sv
// ---------------------------------------------------------------------------
// saikoro_roll_ctrl_if
//   Button-in / dice-control-out bundle of the roll controller.
//   btn     : raw push-button, active high, asynchronous, may bounce
//   enable  : advance strobe to the saikoro counter
//   rolling : dice are spinning or slowing down
//   done    : one-cycle pulse when the result is frozen
//   master  : button/observer side; slave : the roll controller
// ---------------------------------------------------------------------------
interface saikoro_roll_ctrl_if;
  logic btn;
  logic enable;
  logic rolling;
  logic done;

  modport master (output btn, input enable, input rolling, input done);
  modport slave  (input btn, output enable, output rolling, output done);
endinterface

// File: rtl/saikoro_roll_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser followed by a stability counter. btn_db follows the
//   synchronised button only after it has differed from btn_db for
//   DEBOUNCE_CYCLES consecutive samples; any return to the accepted level
//   restarts the count, so short pulses never reach btn_db.
//   ck     : clock, rising edge
//   reset  : asynchronous, active low
//   btn    : raw button
//   btn_db : debounced level
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic ck,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the button and count consecutive samples that disagree with btn_db
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // This sample completes the stable run: accept the new level.
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign btn_db = r_db;

endmodule

// File: rtl/saikoro_roll_ctrl.sv
// ---------------------------------------------------------------------------
// saikoro_roll_ctrl
//   Turns a push-button into the saikoro enable stream: free spin while the
//   button is held, then SLOW_STEPS pulses at doubling intervals after
//   release, then a one-cycle done when the result is frozen.
//   ck    : clock, rising edge
//   reset : asynchronous, active low, clears every register
//   bus   : slave side of saikoro_roll_ctrl_if (btn in; enable/rolling/done out)
//   All outputs are registered and are computed from the state being entered,
//   so enable is high exactly in the cycles that the state/gap counter call a
//   pulse, and never in IDLE or HOLD.
// ---------------------------------------------------------------------------
module saikoro_roll_ctrl
  import saikoro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BASE_GAP        = BASE_GAP_DEF,
  parameter int SLOW_STEPS      = SLOW_STEPS_DEF
) (
  input  logic               ck,
  input  logic               reset,
  saikoro_roll_ctrl_if.slave bus
);

  localparam int               GAP_W     = gap_width(BASE_GAP, SLOW_STEPS);
  localparam int               STEP_W    = $clog2(SLOW_STEPS + 1);
  localparam logic [GAP_W-1:0] GAP_BASE  = GAP_W'(BASE_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SLOW_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  logic              w_btn_db;
  logic              w_rise;
  logic              w_fall;
  logic              r_db_d;
  roll_state_e       r_state;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [STEP_W-1:0] r_step;
  logic              r_enable;
  logic              r_rolling;
  logic              r_done;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .ck     (ck),
    .reset  (reset),
    .btn    (bus.btn),
    .btn_db (w_btn_db)
  );

  assign w_rise = w_btn_db & ~r_db_d;
  assign w_fall = ~w_btn_db & r_db_d;

  // Roll FSM, slow-down gap counters and registered outputs
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_db_d    <= 1'b0;
      r_state   <= ST_IDLE;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_step    <= '0;
      r_enable  <= 1'b0;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_db_d <= w_btn_db;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_rise) begin
            r_state   <= ST_SPIN;
            r_enable  <= 1'b1;
            r_rolling <= 1'b1;
          end else begin
            r_enable  <= 1'b0;
            r_rolling <= 1'b0;
          end
        end
        ST_SPIN: begin
          r_rolling <= 1'b1;
          if (w_fall) begin
            r_state   <= ST_SLOW;
            r_gap     <= GAP_BASE;
            r_gap_cnt <= GAP_BASE;
            r_step    <= '0;
            r_enable  <= 1'b0;        // BASE_GAP >= 1: the slow-down starts idle
          end else begin
            r_enable  <= 1'b1;
          end
        end
        ST_SLOW: begin
          if (w_rise) begin
            // A re-press abandons the slow-down, even on the final pulse.
            r_state   <= ST_SPIN;
            r_enable  <= 1'b1;
            r_rolling <= 1'b1;
          end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
            r_enable  <= (r_gap_cnt == GAP_ONE);
            r_rolling <= 1'b1;
          end else begin
            // This cycle is a pulse; the next gap is twice the old one.
            r_step    <= r_step + STEP_ONE;
            r_gap     <= {r_gap[GAP_W-2:0], 1'b0};
            r_gap_cnt <= {r_gap[GAP_W-2:0], 1'b0};
            r_enable  <= 1'b0;
            if ((r_step + STEP_ONE) == STEP_LAST) begin
              r_state   <= ST_HOLD;
              r_rolling <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_rolling <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_enable  <= 1'b0;
          r_rolling <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable  = r_enable;
  assign bus.rolling = r_rolling;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_saikoro_roll_ctrl.sv
`timescale 1ns/1ps
module tb_saikoro_roll_ctrl;

  logic ck    = 1'b0;
  logic reset = 1'b0;

  saikoro_roll_ctrl_if bus ();

  saikoro_roll_ctrl dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ck = ~ck;

  int n_vec = 0;
  int n_err = 0;

  // Downstream saikoro lamp model: 1..6, advances on each enable cycle.
  int dice;
  always @(posedge ck or negedge reset) begin
    if (!reset) dice <= 1;
    else if (bus.enable) dice <= (dice == 6) ? 1 : dice + 1;
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // 1: reset held, button toggling
  task automatic test_reset();
    reset   = 1'b0;
    bus.btn = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      bus.btn = ~bus.btn;
      step();
      n_vec++;
      if ({bus.enable, bus.rolling, bus.done} !== 3'b000 || dice !== 1) begin
        n_err++;
        $display("FAIL reset e=%0d erd=%b%b%b dice=%0d expected erd=000 dice=1",
                 e, bus.enable, bus.rolling, bus.done, dice);
      end
    end
    bus.btn = 1'b0;
    reset   = 1'b1;
    for (int e = 1; e <= 6; e++) step();
    n_vec++;
    if ({bus.enable, bus.rolling, bus.done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_release erd=%b%b%b expected 000", bus.enable, bus.rolling, bus.done);
    end
  endtask

  // 2: two-cycle button pulse never reaches btn_db
  task automatic test_glitch();
    bus.btn = 1'b1;
    step();
    step();
    bus.btn = 1'b0;
    for (int e = 3; e <= 14; e++) begin
      step();
      n_vec++;
      if (bus.enable !== 1'b0 || dut.w_btn_db !== 1'b0) begin
        n_err++;
        $display("FAIL glitch e=%0d enable=%b btn_db=%b expected 0 0", e, bus.enable, dut.w_btn_db);
      end
    end
  endtask

  // 3: press 10 cycles from IDLE, release, full slow-down to HOLD
  task automatic test_full_roll();
    logic xe, xr, xd;
    bus.btn = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 10) bus.btn = 1'b0;
      xe = (e >= 7 && e <= 16) || e == 18 || e == 21 || e == 26 || e == 35;
      xr = (e >= 7 && e <= 35);
      xd = (e == 36);
      n_vec++;
      if ({bus.enable, bus.rolling, bus.done} !== {xe, xr, xd}) begin
        n_err++;
        $display("FAIL full_roll e=%0d erd=%b%b%b expected %b%b%b",
                 e, bus.enable, bus.rolling, bus.done, xe, xr, xd);
      end
    end
    // 14 advances from 1: wraps twice, lands on 3.
    n_vec++;
    if (dice !== 3) begin
      n_err++;
      $display("FAIL dice_count got %0d expected 3", dice);
    end
  endtask

  // 6: new press from HOLD; released, runs to the 2nd slow pulse
  task automatic test_hold_reroll();
    logic xe, xr;
    bus.btn = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      step();
      if (e == 10) bus.btn = 1'b0;
      xe = (e >= 7 && e <= 16) || e == 18 || e == 21;
      xr = (e >= 7);
      n_vec++;
      if ({bus.enable, bus.rolling, bus.done} !== {xe, xr, 1'b0}) begin
        n_err++;
        $display("FAIL hold_reroll e=%0d erd=%b%b%b expected %b%b0",
                 e, bus.enable, bus.rolling, bus.done, xe, xr);
      end
    end
  endtask

  // 4: re-press right after the 2nd slow pulse -> SPIN, no done
  task automatic test_repress_slow();
    logic xe;
    bus.btn = 1'b1;
    for (int e = 22; e <= 40; e++) begin
      step();
      xe = (e == 26) || (e >= 28);
      n_vec++;
      if ({bus.enable, bus.rolling, bus.done} !== {xe, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL repress_slow e=%0d erd=%b%b%b expected %b10",
                 e, bus.enable, bus.rolling, bus.done, xe);
      end
    end
  endtask

  // 5: one-cycle reset while spinning with the button still held
  task automatic test_reset_mid_spin();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.enable, bus.rolling, bus.done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_async erd=%b%b%b expected 000", bus.enable, bus.rolling, bus.done);
    end
    step();
    reset = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      n_vec++;
      if ({bus.enable, bus.rolling} !== {2{e >= 7}}) begin
        n_err++;
        $display("FAIL reset_respin e=%0d er=%b%b expected %b%b",
                 e, bus.enable, bus.rolling, e >= 7, e >= 7);
      end
    end
  endtask

  // Release from SPIN with btn_db already high: shorter path into SLOW
  task automatic test_release_to_hold();
    logic xe, xr, xd;
    bus.btn = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step();
      xe = (e <= 6) || e == 8 || e == 11 || e == 16 || e == 25;
      xr = (e <= 25);
      xd = (e == 26);
      n_vec++;
      if ({bus.enable, bus.rolling, bus.done} !== {xe, xr, xd}) begin
        n_err++;
        $display("FAIL release_to_hold e=%0d erd=%b%b%b expected %b%b%b",
                 e, bus.enable, bus.rolling, bus.done, xe, xr, xd);
      end
    end
  endtask

  // btn_db rises in the same cycle as the final slow pulse: pulse kept, SPIN wins
  task automatic test_race_final_pulse();
    logic xe, xr;
    bus.btn = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 10) bus.btn = 1'b0;
      if (e == 29) bus.btn = 1'b1;
      xe = (e >= 7 && e <= 16) || e == 18 || e == 21 || e == 26 || e >= 35;
      xr = (e >= 7);
      n_vec++;
      if ({bus.enable, bus.rolling, bus.done} !== {xe, xr, 1'b0}) begin
        n_err++;
        $display("FAIL race_final e=%0d erd=%b%b%b expected %b%b0",
                 e, bus.enable, bus.rolling, bus.done, xe, xr);
      end
    end
  endtask

  initial begin
    bus.btn = 1'b0;
    test_reset();
    test_glitch();
    test_full_roll();
    test_hold_reroll();
    test_repress_slow();
    test_reset_mid_spin();
    test_release_to_hold();
    test_race_final_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
